video_pixel_feeder: RTL
=======================

Name: video_pixel_feeder

Overview:
- Upstream stage of the HDMI/DVI timing generator. Sits between the DDR read-side FIFO (first-word-fall-through, 24-bit RGB888, pixel_clk domain) and the timing generator's data_req/pixel_data interface.
- Delivers one pixel per data_req with one-cycle registered latency.
- At every vertical sync it drains stale FIFO words and pulses a frame restart request to the DDR read master.
- Masks FIFO underflow with a fill colour.

Parameters:
- H_DISP, 1920, active pixels per line.
- V_DISP, 1080, active lines per frame.
- PIX_CNT_W, 22, width of the per-frame pixel counter; must hold H_DISP*V_DISP.
- FILL_COLOR, 24'h000000, pixel value driven on underflow or outside a served frame.
- DRAIN_MAX, 16'd4096, maximum drain cycles per vertical sync.

Ports:
- pixel_clk  in  1  pixel clock; the only clock.
- sys_rst_n  in  1  synchronous active-low reset.
- video_vs  in  1  vertical sync from timing generator, active low.
- data_req  in  1  pixel request, asserted one cycle before each active pixel.
- pixel_data  out  24  RGB888 pixel to timing generator.
- fifo_dout  in  24  FIFO head word (FWFT).
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_en  out  1  FIFO pop, combinational.
- frame_req  out  1  one-cycle pulse: DDR read master restarts at frame base address.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is served.
- underflow  out  1  sticky flag: current frame had at least one underflow.
- underflow_cnt  out  16  saturating underflow count (see Optional Feature).

Behaviour:
- Reset values (sys_rst_n low at a pixel_clk edge):
  - Outputs: pixel_data=0, frame_req=0, frame_done=0, underflow=0, underflow_cnt=0.
  - Internal: state=IDLE, vs_d=1, pix_cnt=0, drain_cnt=0.
  - fifo_rd_en is 0 while in reset.
- vs_fall = vs_d & ~video_vs; vs_d is registered every cycle.
- vs_fall has top priority in every state: next state=DRAIN, pix_cnt=0, drain_cnt=0. A vs_fall during DRAIN restarts the drain.
- IDLE:
  - fifo_rd_en=0.
  - On data_req: pixel_data<=FILL_COLOR; no underflow counted.
  - Waits for vs_fall.
- DRAIN:
  - fifo_rd_en = ~fifo_empty; drain_cnt increments each cycle.
  - Go to REQ when fifo_empty=1 or drain_cnt==DRAIN_MAX-1.
  - data_req here is served FILL_COLOR without popping.
- REQ:
  - Exactly one cycle: frame_req=1, underflow<=0.
  - Next state ACTIVE.
- ACTIVE, on a data_req cycle:
  - If ~fifo_empty: fifo_rd_en=1, pixel_data<=fifo_dout.
  - Else: fifo_rd_en=0, pixel_data<=FILL_COLOR, underflow<=1, underflow_cnt increments (saturates at 16'hFFFF).
  - pix_cnt increments on every data_req, hit or miss.
  - When data_req occurs with pix_cnt==H_DISP*V_DISP-1: frame_done=1 next cycle, state->IDLE, pix_cnt->0.
- ACTIVE, no data_req: fifo_rd_en=0.
- Latency and hold: pixel_data updates only on the edge ending a data_req cycle, i.e. valid exactly one cycle after data_req, aligned with video_de. It holds its value otherwise.
- fifo_rd_en is never asserted while fifo_empty=1.
- Arithmetic: the frame size compare uses a PIX_CNT_W-bit constant. The drain counter is 16-bit.
- Reset mid-frame: all state returns to reset values on the next edge; the FIFO is not touched.
- Simultaneous vs_fall and data_req in ACTIVE: vs_fall wins; no pop; pixel_data<=FILL_COLOR.

Optional Feature:
- Macro: VIDEO_PIXEL_FEEDER_STATS_EN.
- Defined: underflow_cnt is a 16-bit saturating counter. It is cleared only by reset and counts underflows in ACTIVE across frames.
- Undefined: no counter is built; underflow_cnt is tied to 16'd0. The underflow flag is unaffected.

Test Plan:
All scenarios use H_DISP=4, V_DISP=2, FILL_COLOR=24'hFF00FF, DRAIN_MAX=8.
- Reset then vs_fall, FIFO preloaded with 3 stale words -> 3 pops in DRAIN; frame_req pulses once, one cycle after fifo_empty is seen.
- Full frame, FIFO holds 8 words 0x000001..0x000008, 8 data_req pulses -> pixel_data=0x000001..0x000008, each one cycle after its data_req; frame_done pulses once after the 8th; state IDLE; underflow=0.
- FIFO empty on the 3rd data_req of a frame -> pixel_data=24'hFF00FF for that pixel; underflow=1; underflow_cnt=1 (macro defined) or 0 (undefined); pixel 4 resumes with FIFO data.
- FIFO never empties in DRAIN (writer keeps filling) -> exit after exactly 8 drain cycles; frame_req pulses.
- vs_fall after 5 of 8 pixels -> no further pops; drain restarts; frame_done not asserted; pix_cnt restarts at 0; underflow cleared at next frame_req.
- sys_rst_n low for one cycle mid-ACTIVE -> all outputs 0 next cycle; data_req in IDLE yields FILL_COLOR with no fifo_rd_en.

Source files
------------

// File: rtl/video_pixel_feeder.sv
// Pixel feeder between the FWFT read FIFO and the HDMI/DVI timing generator.
// Optional underflow statistics counter: define VIDEO_PIXEL_FEEDER_STATS_EN.
module video_pixel_feeder #(
    parameter int          H_DISP     = 1920,
    parameter int          V_DISP     = 1080,
    parameter int          PIX_CNT_W  = 22,
    parameter logic [23:0] FILL_COLOR = 24'h000000,
    parameter logic [15:0] DRAIN_MAX  = 16'd4096
) (
    input  logic        pixel_clk,
    input  logic        sys_rst_n,
    input  logic        video_vs,
    input  logic        data_req,
    output logic [23:0] pixel_data,
    input  logic [23:0] fifo_dout,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic        frame_req,
    output logic        frame_done,
    output logic        underflow,
    output logic [15:0] underflow_cnt,
    output logic [1:0]  dbg_state
);

    localparam logic [PIX_CNT_W-1:0] FRAME_LAST = PIX_CNT_W'(H_DISP * V_DISP - 1);
    localparam logic [15:0]          DRAIN_LAST = DRAIN_MAX - 16'd1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        REQ    = 2'd2,
        ACTIVE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_vs_d;
    logic [PIX_CNT_W-1:0]  r_pix_cnt;
    logic [15:0]           r_drain_cnt;
    logic [23:0]           r_pixel;
    logic                  r_frame_done;
    logic                  r_underflow;
    logic                  w_vs_fall;
    logic                  w_serve;
    logic                  w_hit;
    logic                  w_miss;
    logic                  w_last;
    logic                  w_rd_en;

    // A vsync falling edge pre-empts pixel service in the same cycle.
    assign w_vs_fall = r_vs_d & ~video_vs;
    assign w_serve   = (r_state == ACTIVE) & data_req & ~w_vs_fall;
    assign w_hit     = w_serve & ~fifo_empty;
    assign w_miss    = w_serve & fifo_empty;
    assign w_last    = w_serve & (r_pix_cnt == FRAME_LAST);

    always_comb begin
        w_next  = r_state;
        w_rd_en = 1'b0;
        if (w_vs_fall) begin
            w_next = DRAIN;
        end else begin
            case (r_state)
                IDLE: w_next = IDLE;
                DRAIN: begin
                    w_rd_en = ~fifo_empty;
                    if (fifo_empty || (r_drain_cnt == DRAIN_LAST))
                        w_next = REQ;
                end
                REQ: w_next = ACTIVE;
                ACTIVE: begin
                    w_rd_en = w_hit;
                    if (w_last)
                        w_next = IDLE;
                end
                default: w_next = IDLE;
            endcase
        end
    end

    assign fifo_rd_en = sys_rst_n & w_rd_en;
    assign frame_req  = (r_state == REQ);
    assign pixel_data = r_pixel;
    assign frame_done = r_frame_done;
    assign underflow  = r_underflow;
    assign dbg_state  = r_state;

    always_ff @(posedge pixel_clk) begin
        if (!sys_rst_n) begin
            r_state      <= IDLE;
            r_vs_d       <= 1'b1;
            r_pix_cnt    <= '0;
            r_drain_cnt  <= '0;
            r_pixel      <= '0;
            r_frame_done <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_vs_d       <= video_vs;
            r_frame_done <= w_last;
            if (data_req)
                r_pixel <= w_hit ? fifo_dout : FILL_COLOR;
            if (w_vs_fall)
                r_pix_cnt <= '0;
            else if (w_serve)
                r_pix_cnt <= w_last ? '0 : r_pix_cnt + 1'b1;
            if (w_vs_fall)
                r_drain_cnt <= '0;
            else if (r_state == DRAIN)
                r_drain_cnt <= r_drain_cnt + 16'd1;
            if (r_state == REQ)
                r_underflow <= 1'b0;
            else if (w_miss)
                r_underflow <= 1'b1;
        end
    end

`ifdef VIDEO_PIXEL_FEEDER_STATS_EN
    logic [15:0] r_uf_cnt;

    // Counts across frames; only reset clears it.
    always_ff @(posedge pixel_clk) begin
        if (!sys_rst_n)
            r_uf_cnt <= '0;
        else if (w_miss && (r_uf_cnt != 16'hFFFF))
            r_uf_cnt <= r_uf_cnt + 16'd1;
    end

    assign underflow_cnt = r_uf_cnt;
`else
    assign underflow_cnt = 16'd0;
`endif

endmodule
